// File: rtl/pc_core_pkg.sv
// Shared definitions for param_pc_core: opcodes, FSM states and instruction-field helpers.
package pc_core_pkg;

    localparam logic [3:0] OpHalt = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpXchg = 4'h3;
    localparam logic [3:0] OpRcl  = 4'h4;
    localparam logic [3:0] OpShr  = 4'h5;
    localparam logic [3:0] OpMov  = 4'h6;
    localparam logic [3:0] OpXor  = 4'h7;
    localparam logic [3:0] OpAnd  = 4'h8;
    localparam logic [3:0] OpOr   = 4'h9;
    localparam logic [3:0] OpOut  = 4'hA;
    localparam logic [3:0] OpJz   = 4'hB;
    localparam logic [3:0] OpPush = 4'hC;
    localparam logic [3:0] OpPop  = 4'hD;
    localparam logic [3:0] OpCall = 4'hE;
    localparam logic [3:0] OpRet  = 4'hF;

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    // Instruction word is {opcode[3:0], operand[aw-1:0]}, passed zero-extended to 32 bits.
    function automatic logic [3:0] ir_opcode(input logic [31:0] ir, input int unsigned aw);
        return 4'(ir >> aw);
    endfunction

    function automatic logic [31:0] ir_operand(input logic [31:0] ir, input int unsigned aw);
        return ir & ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/pc_core_stack.sv
// Synchronous LIFO of SD entries, DW bits wide; top of stack is read combinationally.
module pc_core_stack
    import pc_core_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned SD = 4,
    localparam int unsigned CW = $clog2(SD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int unsigned IW = (SD > 1) ? $clog2(SD) : 1;

    logic [DW-1:0] mem [SD];
    logic [CW-1:0] cnt;

    assign count = cnt;
    assign full  = (cnt == CW'(SD));
    assign empty = (cnt == '0);
    assign rdata = empty ? '0 : mem[IW'(cnt - CW'(1))];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[IW'(cnt)] <= wdata;
        end
    end

endmodule

// File: rtl/param_pc_core.sv
// Two-cycle (FETCH/EXEC) accumulator core with loadable program RAM, data RAM and a bounded
// call/data stack; stack overflow or underflow halts the core with a sticky error.
module param_pc_core
    import pc_core_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4,
    parameter int unsigned SD = 4,
    localparam int unsigned SPW = $clog2(SD + 1),
    localparam int unsigned IRW = 4 + AW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DW-1:0]  in_a,
    input  logic [DW-1:0]  in_b,
    input  logic           prog_we,
    input  logic [AW-1:0]  prog_addr,
    input  logic [IRW-1:0] prog_data,
    output logic [DW-1:0]  a_out,
    output logic [DW-1:0]  b_out,
    output logic           carry_flag,
    output logic           zero_flag,
    output logic [AW-1:0]  pc,
    output logic [SPW-1:0] sp,
    output logic [DW-1:0]  out_port,
    output logic           out_valid,
    output logic           halted,
    output logic           stack_err
);
    if (DW < AW) begin : gen_bad_width
        $error("param_pc_core: DW must be at least AW");
    end

    logic [IRW-1:0] pmem [2**AW];
    logic [DW-1:0]  dmem [2**AW];

    state_e         state;
    logic [IRW-1:0] ir;
    logic [3:0]     opcode;
    logic [AW-1:0]  operand;
    logic           exec, stopped, start_ok;
    logic           is_push, is_pop, st_err, st_push, st_pop, st_full, st_empty;
    logic [DW-1:0]  st_top, st_wdata, dmem_rd, diff;
    logic [DW:0]    sum, rcl;

    assign opcode   = ir_opcode(32'(ir), AW);
    assign operand  = AW'(ir_operand(32'(ir), AW));
    assign exec     = (state == StExec);
    assign stopped  = (state == StIdle) || (state == StHalt);
    assign start_ok = start && stopped;

    assign is_push  = (opcode == OpPush) || (opcode == OpCall);
    assign is_pop   = (opcode == OpPop) || (opcode == OpRet);
    assign st_err   = exec && ((is_push && st_full) || (is_pop && st_empty));
    assign st_push  = exec && is_push && !st_full;
    assign st_pop   = exec && is_pop && !st_empty;
    // pc already points past the CALL, so it is the return address.
    assign st_wdata = (opcode == OpCall) ? DW'(pc) : b_out;

    assign dmem_rd  = dmem[operand];
    assign sum      = {1'b0, a_out} + {1'b0, b_out};
    assign diff     = a_out - b_out;
    assign rcl      = {b_out, carry_flag};

    pc_core_stack #(
        .DW(DW),
        .SD(SD)
    ) u_stack (
        .clk  (clk),
        .rst  (rst || start_ok),
        .push (st_push),
        .pop  (st_pop),
        .wdata(st_wdata),
        .rdata(st_top),
        .full (st_full),
        .empty(st_empty),
        .count(sp)
    );

    always_ff @(posedge clk) begin
        if (prog_we && stopped) begin
            pmem[prog_addr] <= prog_data;
        end
        if (!rst && exec && opcode == OpMov) begin
            dmem[operand] <= a_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            ir         <= '0;
            pc         <= '0;
            a_out      <= '0;
            b_out      <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            out_port   <= '0;
            out_valid  <= 1'b0;
            halted     <= 1'b0;
            stack_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                StIdle, StHalt: begin
                    if (start) begin
                        state      <= StFetch;
                        halted     <= 1'b0;
                        pc         <= '0;
                        a_out      <= in_a;
                        b_out      <= in_b;
                        carry_flag <= 1'b0;
                        zero_flag  <= 1'b0;
                        stack_err  <= 1'b0;
                    end
                end
                StFetch: begin
                    ir    <= pmem[pc];
                    pc    <= pc + AW'(1);
                    state <= StExec;
                end
                StExec: begin
                    state <= StFetch;
                    if (st_err) begin
                        stack_err <= 1'b1;
                        halted    <= 1'b1;
                        state     <= StHalt;
                    end else begin
                        case (opcode)
                            OpHalt: begin
                                halted <= 1'b1;
                                state  <= StHalt;
                            end
                            OpAdd: begin
                                {carry_flag, a_out} <= sum;
                                zero_flag <= (sum[DW-1:0] == '0);
                            end
                            OpSub: begin
                                a_out      <= diff;
                                carry_flag <= (a_out < b_out);
                                zero_flag  <= (diff == '0);
                            end
                            OpXchg: begin
                                a_out <= b_out;
                                b_out <= a_out;
                            end
                            OpRcl: begin
                                {carry_flag, b_out} <= rcl;
                                zero_flag <= (rcl[DW-1:0] == '0);
                            end
                            OpShr: begin
                                carry_flag <= a_out[0];
                                a_out      <= a_out >> 1;
                                zero_flag  <= ((a_out >> 1) == '0);
                            end
                            OpXor: begin
                                a_out     <= a_out ^ dmem_rd;
                                zero_flag <= ((a_out ^ dmem_rd) == '0);
                            end
                            OpAnd: begin
                                a_out     <= a_out & b_out;
                                zero_flag <= ((a_out & b_out) == '0);
                            end
                            OpOr: begin
                                b_out     <= b_out | dmem_rd;
                                zero_flag <= ((b_out | dmem_rd) == '0);
                            end
                            OpOut: begin
                                out_port  <= a_out;
                                out_valid <= 1'b1;
                            end
                            OpJz: begin
                                if (zero_flag) begin
                                    pc <= operand;
                                end
                            end
                            OpPop:  b_out <= st_top;
                            OpCall: pc <= operand;
                            OpRet:  pc <= st_top[AW-1:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_param_pc_core.sv
// Randomised and directed bench for param_pc_core against an instruction-level reference model.
module tb_param_pc_core;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst, start, prog_we;
    logic [7:0] in_a, in_b, prog_data;
    logic [3:0] prog_addr;
    logic [7:0] a_out, b_out, out_port;
    logic       carry_flag, zero_flag, out_valid, halted, stack_err;
    logic [3:0] pc;
    logic [2:0] sp;

    param_pc_core #(
        .DW(8),
        .AW(4),
        .SD(SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_a      (in_a),
        .in_b      (in_b),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .a_out     (a_out),
        .b_out     (b_out),
        .carry_flag(carry_flag),
        .zero_flag (zero_flag),
        .pc        (pc),
        .sp        (sp),
        .out_port  (out_port),
        .out_valid (out_valid),
        .halted    (halted),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;

    // Reference model: mode 0 idle, 1 about to fetch, 2 about to execute, 3 halted.
    int m_mode = 0;
    int m_a = 0, m_b = 0, m_c = 0, m_z = 0, m_pc = 0, m_ir = 0;
    int m_out = 0, m_outv = 0, m_err = 0;
    int m_stk[$];
    int pmem[16];
    int dmem[16];
    int prog[16];

    task automatic chk(input string nm, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, nm, got, exp);
        end
    endtask

    task automatic model_tick();
        int op, n, t;
        m_outv = 0;
        if (rst) begin
            m_mode = 0; m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_pc = 0; m_ir = 0;
            m_out = 0; m_err = 0;
            m_stk.delete();
            return;
        end
        if (prog_we && (m_mode == 0 || m_mode == 3)) pmem[prog_addr] = int'(prog_data);
        case (m_mode)
            0, 3: begin
                if (start) begin
                    m_mode = 1; m_pc = 0; m_a = int'(in_a); m_b = int'(in_b);
                    m_c = 0; m_z = 0; m_err = 0;
                    m_stk.delete();
                end
            end
            1: begin
                m_ir = pmem[m_pc];
                m_pc = (m_pc + 1) % 16;
                m_mode = 2;
            end
            default: begin
                op = m_ir / 16;
                n = m_ir % 16;
                m_mode = 1;
                case (op)
                    0: m_mode = 3;
                    1: begin t = m_a + m_b; m_c = int'(t > 255); m_a = t % 256; end
                    2: begin m_c = int'(m_a < m_b); m_a = (m_a - m_b + 256) % 256; end
                    3: begin t = m_a; m_a = m_b; m_b = t; end
                    4: begin t = m_b * 2 + m_c; m_c = t / 256; m_b = t % 256; end
                    5: begin m_c = m_a % 2; m_a = m_a / 2; end
                    6: dmem[n] = m_a;
                    7: m_a = m_a ^ dmem[n];
                    8: m_a = m_a & m_b;
                    9: m_b = m_b | dmem[n];
                    10: begin m_out = m_a; m_outv = 1; end
                    11: if (m_z != 0) m_pc = n;
                    12, 14: begin
                        if (m_stk.size() == SD) begin
                            m_err = 1; m_mode = 3;
                        end else if (op == 12) begin
                            m_stk.push_back(m_b);
                        end else begin
                            m_stk.push_back(m_pc); m_pc = n;
                        end
                    end
                    default: begin
                        if (m_stk.size() == 0) begin
                            m_err = 1; m_mode = 3;
                        end else if (op == 13) begin
                            m_b = m_stk.pop_back();
                        end else begin
                            m_pc = m_stk.pop_back() % 16;
                        end
                    end
                endcase
                if (m_err == 0) begin
                    if (op == 1 || op == 2 || op == 5 || op == 7 || op == 8) m_z = int'(m_a == 0);
                    if (op == 4 || op == 9) m_z = int'(m_b == 0);
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        cyc++;
        chk("a_out", 32'(a_out), m_a);
        chk("b_out", 32'(b_out), m_b);
        chk("carry", 32'(carry_flag), m_c);
        chk("zero", 32'(zero_flag), m_z);
        chk("pc", 32'(pc), m_pc);
        chk("sp", 32'(sp), m_stk.size());
        chk("out_port", 32'(out_port), m_out);
        chk("out_valid", 32'(out_valid), m_outv);
        chk("halted", 32'(halted), int'(m_mode == 3));
        chk("stack_err", 32'(stack_err), m_err);
    endtask

    task automatic quiet();
        rst = 1'b0; start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1;
            prog_addr = 4'(i);
            prog_data = 8'(prog[i]);
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic do_start(input int a, input int b);
        start = 1'b1; in_a = 8'(a); in_b = 8'(b);
        step();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input int max);
        int k = 0;
        pulses = 0;
        while (!halted && k < max) begin
            step();
            if (out_valid) pulses++;
            k++;
        end
        chk("halt_reached", 32'(halted), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0;
        in_a = '0; in_b = '0; prog_addr = '0; prog_data = '0;
        for (int i = 0; i < 16; i++) begin pmem[i] = 0; dmem[i] = 0; end
        step();
        step();
        chk("rst_a", 32'(a_out), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", 32'(pc), 0);
        quiet();

        // Fill the data RAM so later XOR/OR reads are defined.
        for (int i = 0; i < 15; i++) prog[i] = 8'h60 + i;
        prog[15] = 0;
        load_prog();
        do_start($urandom_range(0, 255), 0);
        run_to_halt(40);
        clear_prog();
        prog[0] = 8'h6F;
        load_prog();
        do_start($urandom_range(0, 255), 0);
        run_to_halt(10);

        // ADD with carry: result at start+3, halted at start+5.
        clear_prog();
        prog[0] = 8'h10;
        load_prog();
        do_start(8'hFF, 8'h01);
        step();
        step();
        chk("add_a", 32'(a_out), 0);
        chk("add_c", 32'(carry_flag), 1);
        chk("add_z", 32'(zero_flag), 1);
        step();
        chk("add_not_yet_halted", 32'(halted), 0);
        step();
        chk("add_halted", 32'(halted), 1);

        // SUB with borrow then OUT.
        clear_prog();
        prog[0] = 8'h20; prog[1] = 8'hA0;
        load_prog();
        do_start(8'h05, 8'h07);
        run_to_halt(20);
        chk("sub_out", 32'(out_port), 8'hFE);
        chk("sub_c", 32'(carry_flag), 1);
        chk("sub_z", 32'(zero_flag), 0);
        chk("sub_pulses", 32'(pulses), 1);

        // CALL / RET.
        clear_prog();
        prog[0] = 8'hE4; prog[1] = 8'hA0; prog[4] = 8'h10; prog[5] = 8'hF0;
        load_prog();
        do_start(8'h10, 8'h22);
        run_to_halt(30);
        chk("call_out", 32'(out_port), 8'h32);
        chk("call_sp", 32'(sp), 0);
        chk("call_pc", 32'(pc), 3);

        // JZ taken skips OUT.
        clear_prog();
        prog[0] = 8'h20; prog[1] = 8'hB3; prog[2] = 8'hA0;
        load_prog();
        do_start(8'h03, 8'h03);
        run_to_halt(20);
        chk("jz_z", 32'(zero_flag), 1);
        chk("jz_pulses", 32'(pulses), 0);
        chk("jz_pc", 32'(pc), 4);

        // Overflow on the fifth PUSH.
        clear_prog();
        for (int i = 0; i < 5; i++) prog[i] = 8'hC0;
        load_prog();
        do_start(8'h01, 8'h5A);
        run_to_halt(30);
        chk("ovf_err", 32'(stack_err), 1);
        chk("ovf_sp", 32'(sp), 4);
        chk("ovf_pc", 32'(pc), 5);

        // Underflow on POP of an empty stack.
        clear_prog();
        prog[0] = 8'hD0;
        load_prog();
        do_start(8'h01, 8'h02);
        run_to_halt(10);
        chk("unf_err", 32'(stack_err), 1);
        chk("unf_sp", 32'(sp), 0);
        chk("unf_b", 32'(b_out), 8'h02);

        // Reset during EXEC of ADD, then rerun the retained program.
        clear_prog();
        prog[0] = 8'h10;
        load_prog();
        do_start(8'h11, 8'h22);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_a", 32'(a_out), 0);
        chk("mid_rst_pc", 32'(pc), 0);
        chk("mid_rst_err", 32'(stack_err), 0);
        step();
        do_start(8'h11, 8'h22);
        run_to_halt(10);
        chk("rerun_a", 32'(a_out), 8'h33);

        // Random programs with random start/prog_we/rst noise.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 16; i++) prog[i] = int'($urandom_range(0, 255));
            if (halted == 1'b0 && it != 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            load_prog();
            do_start(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            for (int k = 0; k < 50; k++) begin
                rst = ($urandom_range(0, 63) == 0);
                start = ($urandom_range(0, 7) == 0);
                in_a = 8'($urandom_range(0, 255));
                in_b = 8'($urandom_range(0, 255));
                prog_we = ($urandom_range(0, 7) == 0);
                prog_addr = 4'($urandom_range(0, 15));
                prog_data = 8'($urandom_range(0, 255));
                step();
            end
            quiet();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_pc_core.md
# param_pc_core

Parametrised successor to the team's 4-bit instruction-executing PC block. It fetches instructions from an internal, externally loadable program memory and executes them on registers A/B with carry/zero flags. It adds a real program counter, a bounded LIFO stack with overflow/underflow detection, a data RAM, and a HALT state. It sits between a host that loads programs and a consumer of `out_port`.

## Interface
- `DW`, 8: data width of A, B, data RAM and stack entries; must satisfy DW ≥ AW.
- `AW`, 4: address width of the PC, program RAM (2^AW words) and data RAM (2^AW words).
- `SD`, 4: stack depth in entries.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `start`  in  1  begin execution; honoured only in IDLE or HALT.
- `in_a`, `in_b`  in  DW  initial A/B, captured on an accepted `start`.
- `prog_we`  in  1  program RAM write; honoured only in IDLE or HALT.
- `prog_addr`  in  AW  program RAM write address.
- `prog_data`  in  4+AW  instruction word {opcode[3:0], operand[AW-1:0]}.
- `a_out`, `b_out`  out  DW  live A/B registers.
- `carry_flag`, `zero_flag`  out  1  flags.
- `pc`  out  AW  program counter.
- `sp`  out  $clog2(SD+1)  number of stack entries in use.
- `out_port`  out  DW  last value written by OUT.
- `out_valid`  out  1  one-cycle pulse per OUT.
- `halted`  out  1  high in the HALT state.
- `stack_err`  out  1  sticky overflow/underflow indication; cleared by `rst` or an accepted `start`.

## Operation
- FSM states: IDLE → (start) FETCH → EXEC → FETCH … ; EXEC → HALT on opcode 0 or a stack error; HALT → (start) FETCH.
- FETCH: IR ← pmem[pc]; pc ← pc+1, wrapping modulo 2^AW.
- Accepted `start`: pc←0, sp←0, A←`in_a`, B←`in_b`, flags←0, `stack_err`←0.
- Opcodes (operand `n`):
  - 0 HALT.
  - 1 ADD: {C,A}←A+B.
  - 2 SUB: A←A−B; C=borrow (A<B).
  - 3 XCHG: swap A and B.
  - 4 RCL B: {C,B}←{B,C} (rotate through carry).
  - 5 SHR A: C←A[0]; A←A>>1.
  - 6 MOV [n],A: dmem[n]←A.
  - 7 XOR A,[n].
  - 8 AND A,B.
  - 9 OR B,[n].
  - A OUT: `out_port`←A; `out_valid` pulses.
  - B JZ n: if Z, pc←n.
  - C PUSH B.
  - D POP B.
  - E CALL n: push pc (zero-extended to DW); pc←n.
  - F RET: pc←pop[AW-1:0].
- Z is updated only by ops 1, 2, 4, 5, 7, 8, 9: Z set when the destination register is 0. C is updated only by ops 1, 2, 4, 5. All other ops leave flags unchanged.
- Overflow: PUSH or CALL with sp==SD. Underflow: POP or RET with sp==0. On either, no register/stack/pc change, `stack_err`←1, next state HALT.
- `rst`: all outputs and registers return to 0, state IDLE. Program and data RAM contents are retained. Reset mid-instruction aborts it with no partial update.
- `prog_we` together with `start` in IDLE: the write completes in that cycle, and the fetch sees the new word.

## Timing
- Two cycles per instruction: FETCH then EXEC. Results are visible in the cycle after EXEC.
- After `start` in cycle t, the first FETCH is in t+1 and the first result is visible in t+3.
- `out_valid` is high for exactly the cycle after EXEC of OUT.
- `halted` rises in the cycle after EXEC of HALT or of the erroring instruction.
- Data RAM reads are combinational within EXEC. Writes commit at the end of EXEC.

## Structure
- Package `pc_core_pkg` holds the opcode localparams, the FSM state enum, and the instruction-field extract helpers.
- Sub-module `pc_core_stack`: synchronous LIFO (DW×SD) with push/pop, full/empty and count. The core raises errors from its full/empty outputs.

## Test plan
All scenarios use DW=8, AW=4, SD=4.
- ADD carry: in_a=0xFF, in_b=0x01; program ADD, HALT → A=0x00, C=1, Z=1, `halted`=1 at start+5.
- SUB borrow: in_a=0x05, in_b=0x07; program SUB, OUT, HALT → `out_port`=0xFE, C=1, Z=0, one `out_valid` pulse.
- CALL/RET: pmem[0]=CALL 4, [1]=OUT, [2]=HALT, [4]=ADD, [5]=RET; in_a=0x10, in_b=0x22 → `out_port`=0x32, sp=0 at halt, pc=3.
- JZ: in_a=in_b=0x03; program SUB, JZ 3, OUT, HALT → Z=1, no `out_valid`, halted with pc=4.
- Overflow: five PUSH then HALT → `stack_err`=1 and halted after the 5th PUSH, sp=4. POP on an empty stack gives the same error with sp=0.
- Reset mid-run: assert `rst` during the EXEC of ADD → all outputs 0, IDLE. A following `start` reruns the retained program correctly.
